// File: rtl/layer_seq_gen.sv
// Layer-test sequencer: bias -> leakyrelu -> weight -> (feature -> conv -> dma_rx) x TILE_NUM.
// Define SEQ_WATCHDOG_EN to add a 24-bit stall watchdog with a sticky timeout output.
module layer_seq_gen #(
    parameter int          DATA_W         = 64,
    parameter int          TILE_NUM       = 60,
    parameter int          BIAS_LEN       = 8,
    parameter int          LRELU_LEN      = 32,
    parameter int          WEIGHT_LEN     = 1152,
    parameter int          FEAT_LEN       = 4096,
    parameter int          ADDR_W         = 24,
    parameter logic [31:0] CFG_REG1       = 32'h4B5A0101,
    parameter logic [31:0] CFG_REG2       = 32'h09004100,
    parameter logic [31:0] FEAT_CMD_FIRST = 32'h00101181,
    parameter logic [31:0] FEAT_CMD_MID   = 32'h00101381,
    parameter logic [31:0] FEAT_CMD_LAST  = 32'h00041581
) (
    input  logic                  sclk,
    input  logic                  s_rst_n,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  err_early,
    output logic [DATA_W-1:0]     m_axis_mm2s_tdata,
    output logic [DATA_W/8-1:0]   m_axis_mm2s_tkeep,
    output logic                  m_axis_mm2s_tvalid,
    input  logic                  m_axis_mm2s_tready,
    output logic                  m_axis_mm2s_tlast,
    output logic [1:0]            src_sel,
    output logic [ADDR_W-1:0]     src_addr,
    input  logic [DATA_W-1:0]     src_data,
    output logic [31:0]           slave_lite_reg0,
    output logic [31:0]           slave_lite_reg1,
    output logic [31:0]           slave_lite_reg2,
    output logic [31:0]           slave_lite_reg3,
`ifdef SEQ_WATCHDOG_EN
    output logic                  timeout,
`endif
    input  logic                  task_finish
);

    typedef enum logic [7:0] {
        S_IDLE   = 8'h01,
        S_BIAS   = 8'h02,
        S_LRELU  = 8'h04,
        S_WEIGHT = 8'h08,
        S_FEAT   = 8'h10,
        S_CONV   = 8'h20,
        S_RX     = 8'h40,
        S_DONE   = 8'h80
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] beat_cnt_q, beat_cnt_d;
    logic [15:0] tile_cnt_q, tile_cnt_d;
    logic [31:0] reg0_q, reg0_d, reg1_q, reg1_d, reg2_q, reg2_d;
    logic        err_q, err_d;
    logic        tvalid_q, tvalid_d;
    logic [31:0] phase_len;
    logic        is_tx;
    logic        fire;
    logic [63:0] feat_addr;
`ifdef SEQ_WATCHDOG_EN
    logic [23:0] wd_q, wd_d;
    logic        timeout_q, timeout_d;
`endif

    always_comb begin
        phase_len = 32'd0;
        is_tx     = 1'b1;
        src_sel   = 2'd0;
        case (state_q)
            S_BIAS:   begin phase_len = 32'(BIAS_LEN);   src_sel = 2'd0; end
            S_LRELU:  begin phase_len = 32'(LRELU_LEN);  src_sel = 2'd1; end
            S_WEIGHT: begin phase_len = 32'(WEIGHT_LEN); src_sel = 2'd2; end
            S_FEAT:   begin phase_len = 32'(FEAT_LEN);   src_sel = 2'd3; end
            default:  is_tx = 1'b0;
        endcase
    end

    // Feature tiles live back to back in the source address space.
    assign feat_addr = 64'(tile_cnt_q) * 64'(FEAT_LEN) + 64'(beat_cnt_q);

    always_comb begin
        src_addr = '0;
        if (state_q == S_FEAT) begin
            src_addr = feat_addr[ADDR_W-1:0];
        end else if (is_tx) begin
            src_addr = beat_cnt_q[ADDR_W-1:0];
        end
    end

    assign fire = tvalid_q & m_axis_mm2s_tready;

    always_comb begin
        state_d    = state_q;
        beat_cnt_d = fire ? beat_cnt_q + 32'd1 : beat_cnt_q;
        tile_cnt_d = tile_cnt_q;
        reg0_d     = {reg0_q[31:4], 4'h0};
        reg1_d     = reg1_q;
        reg2_d     = reg2_q;
        err_d      = err_q;
        tvalid_d   = 1'b0;
        case (state_q)
            S_IDLE: if (start) begin
                state_d = S_BIAS;
                reg0_d  = 32'h21;
                reg1_d  = CFG_REG1;
                reg2_d  = CFG_REG2;
            end
            S_BIAS:   if (task_finish) begin state_d = S_LRELU;  reg0_d = 32'h31; end
            S_LRELU:  if (task_finish) begin state_d = S_WEIGHT; reg0_d = 32'h11; end
            S_WEIGHT: if (task_finish) begin state_d = S_FEAT;   reg0_d = FEAT_CMD_FIRST; end
            S_FEAT:   if (task_finish) begin state_d = S_CONV;   reg0_d = {reg0_q[31:4], 4'h4}; end
            S_CONV:   if (task_finish) begin state_d = S_RX;     reg0_d = {reg0_q[31:4], 4'h2}; end
            S_RX: if (task_finish) begin
                if (tile_cnt_q == 16'(TILE_NUM - 1)) begin
                    state_d    = S_DONE;
                    tile_cnt_d = '0;
                    reg0_d     = '0;
                end else begin
                    state_d    = S_FEAT;
                    tile_cnt_d = tile_cnt_q + 16'd1;
                    reg0_d     = (tile_cnt_q + 16'd1 == 16'(TILE_NUM - 1)) ? FEAT_CMD_LAST
                                                                           : FEAT_CMD_MID;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                reg0_d  = '0;
                reg1_d  = '0;
                reg2_d  = '0;
            end
            default: state_d = S_IDLE;
        endcase
        if (is_tx && task_finish && (beat_cnt_d < phase_len)) begin
            err_d = 1'b1;
        end
`ifdef SEQ_WATCHDOG_EN
        timeout_d = timeout_q;
        wd_d      = '0;
        if (state_q != S_IDLE && state_q != S_DONE) begin
            if (wd_q == 24'hFFFFFF) begin
                timeout_d  = 1'b1;
                state_d    = S_DONE;
                tile_cnt_d = '0;
                reg0_d     = '0;
            end else if (!task_finish) begin
                wd_d = wd_q + 24'd1;
            end
        end
        if (state_d != state_q) begin
            wd_d = '0;
        end
`endif
        if (state_d != state_q) begin
            beat_cnt_d = '0;
        end
        // Valid is registered, so a phase's first beat is offered one cycle after entry.
        tvalid_d = is_tx && (state_d == state_q) && (beat_cnt_d < phase_len);
    end

    always_ff @(posedge sclk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            state_q    <= S_IDLE;
            beat_cnt_q <= '0;
            tile_cnt_q <= '0;
            reg0_q     <= '0;
            reg1_q     <= '0;
            reg2_q     <= '0;
            err_q      <= 1'b0;
            tvalid_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            beat_cnt_q <= beat_cnt_d;
            tile_cnt_q <= tile_cnt_d;
            reg0_q     <= reg0_d;
            reg1_q     <= reg1_d;
            reg2_q     <= reg2_d;
            err_q      <= err_d;
            tvalid_q   <= tvalid_d;
        end
    end

`ifdef SEQ_WATCHDOG_EN
    always_ff @(posedge sclk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            wd_q      <= '0;
            timeout_q <= 1'b0;
        end else begin
            wd_q      <= wd_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout = timeout_q;
`endif

    assign busy               = (state_q != S_IDLE);
    assign done               = (state_q == S_DONE);
    assign err_early          = err_q;
    assign m_axis_mm2s_tvalid = tvalid_q;
    assign m_axis_mm2s_tlast  = tvalid_q && (beat_cnt_q == phase_len - 32'd1);
    assign m_axis_mm2s_tdata  = tvalid_q ? src_data : '0;
    assign m_axis_mm2s_tkeep  = '1;
    assign slave_lite_reg0    = reg0_q;
    assign slave_lite_reg1    = reg1_q;
    assign slave_lite_reg2    = reg2_q;
    assign slave_lite_reg3    = {16'h0, tile_cnt_q};

endmodule

// File: tb/tb_layer_seq_gen.sv
// Bench for layer_seq_gen: full layer runs with random backpressure and finish delays,
// early-finish error, asynchronous mid-run reset, all checked against a phase-level model.
module tb_layer_seq_gen;

    localparam int          DATA_W     = 64;
    localparam int          TILE_NUM   = 3;
    localparam int          BIAS_LEN   = 8;
    localparam int          LRELU_LEN  = 5;
    localparam int          WEIGHT_LEN = 12;
    localparam int          FEAT_LEN   = 16;
    localparam int          ADDR_W     = 24;
    localparam logic [31:0] CFG1       = 32'h4B5A0101;
    localparam logic [31:0] CFG2       = 32'h09004100;
    localparam logic [31:0] C_FIRST    = 32'h00101181;
    localparam logic [31:0] C_MID      = 32'h00101381;
    localparam logic [31:0] C_LAST     = 32'h00041581;

    logic                sclk = 1'b0;
    logic                s_rst_n = 1'b0;
    logic                start = 1'b0;
    logic                busy, done, err_early;
    logic [DATA_W-1:0]   tdata;
    logic [DATA_W/8-1:0] tkeep;
    logic                tvalid, tlast;
    logic                tready = 1'b0;
    logic [1:0]          src_sel;
    logic [ADDR_W-1:0]   src_addr;
    logic [DATA_W-1:0]   src_data;
    logic [31:0]         reg0, reg1, reg2, reg3;
    logic                task_finish = 1'b0;

    int checks = 0;
    int errors = 0;

    always #5 sclk = ~sclk;

    layer_seq_gen #(
        .DATA_W(DATA_W), .TILE_NUM(TILE_NUM), .BIAS_LEN(BIAS_LEN), .LRELU_LEN(LRELU_LEN),
        .WEIGHT_LEN(WEIGHT_LEN), .FEAT_LEN(FEAT_LEN), .ADDR_W(ADDR_W)
    ) dut (
        .sclk(sclk), .s_rst_n(s_rst_n), .start(start), .busy(busy), .done(done),
        .err_early(err_early), .m_axis_mm2s_tdata(tdata), .m_axis_mm2s_tkeep(tkeep),
        .m_axis_mm2s_tvalid(tvalid), .m_axis_mm2s_tready(tready), .m_axis_mm2s_tlast(tlast),
        .src_sel(src_sel), .src_addr(src_addr), .src_data(src_data),
        .slave_lite_reg0(reg0), .slave_lite_reg1(reg1), .slave_lite_reg2(reg2),
        .slave_lite_reg3(reg3), .task_finish(task_finish)
    );

    // Stand-in for the stimulus ROM: content is a scrambled function of {sel, addr}.
    function automatic logic [63:0] src_fn(input logic [1:0] sel, input logic [ADDR_W-1:0] addr);
        logic [31:0] h;
        h = (32'(addr) * 32'h9E3779B1) ^ 32'(sel);
        return {6'h0, sel, addr, h};
    endfunction

    assign src_data = src_fn(src_sel, src_addr);

    function automatic logic [31:0] tile_cmd(input int t);
        if (t == 0) return C_FIRST;
        if (t == TILE_NUM - 1) return C_LAST;
        return C_MID;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge sclk);
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_done"}, 64'(done), 64'd0);
        chk({tag, "_err"}, 64'(err_early), 64'd0);
        chk({tag, "_tvalid"}, 64'(tvalid), 64'd0);
        chk({tag, "_tlast"}, 64'(tlast), 64'd0);
        chk({tag, "_tdata"}, tdata, 64'd0);
        chk({tag, "_tkeep"}, 64'(tkeep), 64'hFF);
        chk({tag, "_sel"}, 64'(src_sel), 64'd0);
        chk({tag, "_addr"}, 64'(src_addr), 64'd0);
        chk({tag, "_reg0"}, 64'(reg0), 64'd0);
        chk({tag, "_reg1"}, 64'(reg1), 64'd0);
        chk({tag, "_reg2"}, 64'(reg2), 64'd0);
        chk({tag, "_reg3"}, 64'(reg3), 64'd0);
    endtask

    // mode: 0 random tready, 1 tready toggling 1010..., 2 tready always high.
    // Entered on the first cycle of the phase; returns on the first cycle of the next one.
    task automatic tx_phase(input string name, input int sel, input int len, input int tile,
                            input logic [31:0] cmd, input int mode, input int fin_delay);
        int beats = 0;
        int cyc = 0;
        logic tr;
        logic [ADDR_W-1:0] ea;
        chk({name, "_cmd"}, 64'(reg0), 64'(cmd));
        chk({name, "_tvalid_entry"}, 64'(tvalid), 64'd0);
        chk({name, "_reg3"}, 64'(reg3), 64'(tile));
        tick();
        chk({name, "_cmd_cleared"}, 64'(reg0), 64'({cmd[31:4], 4'h0}));
        while (beats < len && cyc < len * 8 + 20) begin
            ea = (sel == 3) ? ADDR_W'(tile * FEAT_LEN + beats) : ADDR_W'(beats);
            chk({name, "_tvalid"}, 64'(tvalid), 64'd1);
            chk({name, "_sel"}, 64'(src_sel), 64'(sel));
            chk({name, "_addr"}, 64'(src_addr), 64'(ea));
            chk({name, "_tdata"}, tdata, src_fn(2'(sel), ea));
            chk({name, "_tlast"}, 64'(tlast), 64'(beats == len - 1));
            if (mode == 0) tr = ($urandom_range(0, 2) != 0);
            else if (mode == 1) tr = ((cyc % 2) == 0);
            else tr = 1'b1;
            tready = tr;
            if (tr) beats++;
            cyc++;
            tick();
        end
        chk({name, "_beats_sent"}, 64'(beats), 64'(len));
        tready = 1'b0;
        repeat (fin_delay) begin
            chk({name, "_tvalid_after"}, 64'(tvalid), 64'd0);
            tick();
        end
        chk({name, "_tvalid_at_finish"}, 64'(tvalid), 64'd0);
        task_finish = 1'b1;
        tick();
        task_finish = 1'b0;
        $display("phase %s tile=%0d beats=%0d cycles=%0d", name, tile, beats, cyc);
    endtask

    task automatic ctl_phase(input string name, input logic [31:0] cmd, input int fin_delay);
        chk({name, "_cmd"}, 64'(reg0), 64'(cmd));
        tick();
        chk({name, "_cmd_cleared"}, 64'(reg0), 64'({cmd[31:4], 4'h0}));
        repeat (fin_delay) begin
            chk({name, "_tvalid"}, 64'(tvalid), 64'd0);
            tick();
        end
        task_finish = 1'b1;
        tick();
        task_finish = 1'b0;
        $display("phase %s cmd=%08h", name, cmd);
    endtask

    task automatic start_layer();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("start_busy", 64'(busy), 64'd1);
        chk("start_reg1", 64'(reg1), 64'(CFG1));
        chk("start_reg2", 64'(reg2), 64'(CFG2));
        chk("start_reg3", 64'(reg3), 64'd0);
    endtask

    // rnd=0: fixed 4-cycle finish delays and 1010 backpressure on weight; rnd=1: random.
    task automatic run_layer(input bit rnd);
        int dl;
        int done_cnt = 0;
        logic [31:0] c;
        start_layer();
        dl = rnd ? int'($urandom_range(0, 5)) : 4;
        tx_phase("bias", 0, BIAS_LEN, 0, 32'h21, rnd ? 0 : 2, dl);
        dl = rnd ? int'($urandom_range(0, 5)) : 4;
        tx_phase("lrelu", 1, LRELU_LEN, 0, 32'h31, rnd ? 0 : 2, dl);
        dl = rnd ? int'($urandom_range(0, 5)) : 4;
        tx_phase("weight", 2, WEIGHT_LEN, 0, 32'h11, rnd ? 0 : 1, dl);
        for (int t = 0; t < TILE_NUM; t++) begin
            c = tile_cmd(t);
            dl = rnd ? int'($urandom_range(0, 5)) : 4;
            tx_phase("feat", 3, FEAT_LEN, t, c, rnd ? 0 : 2, dl);
            ctl_phase("conv", {c[31:4], 4'h4}, rnd ? int'($urandom_range(1, 5)) : 4);
            ctl_phase("rx", {c[31:4], 4'h2}, rnd ? int'($urandom_range(1, 5)) : 4);
        end
        chk("done_pulse", 64'(done), 64'd1);
        chk("done_reg0", 64'(reg0), 64'd0);
        chk("done_busy", 64'(busy), 64'd1);
        chk("done_reg3", 64'(reg3), 64'd0);
        tick();
        repeat (4) begin
            if (done) done_cnt++;
            tick();
        end
        chk("done_once", 64'(done_cnt), 64'd0);
        chk("idle_busy", 64'(busy), 64'd0);
        chk("idle_err", 64'(err_early), 64'd0);
        chk("idle_reg1", 64'(reg1), 64'd0);
        $display("layer complete rnd=%0d", rnd);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        tick();
        tick();
        chk_idle_outputs("reset");
        s_rst_n = 1'b1;
        tick();
        chk_idle_outputs("post_reset");

        // Task finish while idle must not start anything.
        task_finish = 1'b1;
        tick();
        task_finish = 1'b0;
        chk("idle_finish_busy", 64'(busy), 64'd0);

        run_layer(1'b0);

        // Early finish at beat 3 of the bias phase.
        start_layer();
        chk("early_entry_reg0", 64'(reg0), 64'h21);
        tick();
        tready = 1'b1;
        repeat (3) tick();
        chk("early_addr", 64'(src_addr), 64'd3);
        tready = 1'b0;
        task_finish = 1'b1;
        tick();
        task_finish = 1'b0;
        chk("early_err", 64'(err_early), 64'd1);
        chk("early_sel", 64'(src_sel), 64'd1);
        $display("early finish at bias beat 3 err_early=%0b", err_early);
        tx_phase("lrelu", 1, LRELU_LEN, 0, 32'h31, 0, 2);
        tx_phase("weight", 2, WEIGHT_LEN, 0, 32'h11, 0, 2);
        tx_phase("feat", 3, FEAT_LEN, 0, C_FIRST, 0, 2);
        ctl_phase("conv", {C_FIRST[31:4], 4'h4}, 2);
        ctl_phase("rx", {C_FIRST[31:4], 4'h2}, 2);
        chk("sticky_err", 64'(err_early), 64'd1);

        // Asynchronous reset in the middle of feature tile 1.
        chk("tile1_reg0", 64'(reg0), 64'(C_MID));
        tick();
        tready = 1'b1;
        repeat (5) tick();
        chk("tile1_tvalid", 64'(tvalid), 64'd1);
        #2 s_rst_n = 1'b0;
        #1 chk_idle_outputs("async_reset");
        tready = 1'b0;
        tick();
        s_rst_n = 1'b1;
        tick();
        $display("async reset during feature tile 1");

        run_layer(1'b1);
        run_layer(1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
